// File: rtl/irq_encoder_pkg.sv
// irq_encoder_pkg: shared widths, FSM states and idle code for the 8-to-3 interrupt encoder
package irq_encoder_pkg;
    localparam int N_REQ = 8;
    localparam int CODE_W = 3;
    typedef enum logic {ST_IDLE, ST_PRESENT} state_e;
    localparam logic [CODE_W-1:0] CODE_IDLE_N = 3'b111;
endpackage

// File: rtl/prio_find8.sv
// prio_find8: highest-set-bit index of an 8-bit vector, bit 7 wins
module prio_find8
    import irq_encoder_pkg::*;
(
    input  logic [N_REQ-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (vec[i]) idx = CODE_W'(i);
    end
    assign any = |vec;
endmodule

// File: rtl/irq_encoder_8to3.sv
// irq_encoder_8to3: edge-latched, maskable 74148-style priority encoder
// holding the selected code until acknowledged or disabled
module irq_encoder_8to3
    import irq_encoder_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ei_n_i,
    input  logic [N_REQ-1:0]  req_n_i,
    input  logic [N_REQ-1:0]  mask_i,
    input  logic              ack_i,
    output logic [CODE_W-1:0] code_n_o,
    output logic              gs_n_o,
    output logic              valid_o,
    output logic              eo_n_o,
    output logic [N_REQ-1:0]  pending_o
);
    state_e              r_state;
    logic [N_REQ-1:0]    r_req_q, r_pending;
    logic [CODE_W-1:0]   r_code_q;
    logic [N_REQ-1:0]    w_req, w_set, w_clr, w_pend_nx;
    logic [CODE_W-1:0]   w_idx, w_code_nx;
    logic                w_any, w_go, w_leave;
    state_e              w_state_nx;

    prio_find8 u_find (.vec(r_pending & ~mask_i), .idx(w_idx), .any(w_any));

    assign w_req     = ~req_n_i & ~mask_i;
    assign w_set     = w_req & ~r_req_q;
    assign w_clr     = (r_state == ST_PRESENT && ack_i) ? N_REQ'(1) << r_code_q : '0;
    // set after clear so a fresh edge survives a same-cycle ack
    assign w_pend_nx = (r_pending & ~w_clr) | w_set;
    assign w_go      = r_state == ST_IDLE && !ei_n_i && w_any;
    assign w_leave   = r_state == ST_PRESENT && (ack_i || ei_n_i);

    always_comb begin
        w_state_nx = w_go ? ST_PRESENT : w_leave ? ST_IDLE : r_state;
        w_code_nx  = w_go ? w_idx : r_code_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_req_q   <= '0;
            r_pending <= '0;
            r_code_q  <= '0;
            code_n_o  <= CODE_IDLE_N;
            gs_n_o    <= 1'b1;
            valid_o   <= 1'b0;
            eo_n_o    <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_req_q   <= w_req;
            r_pending <= w_pend_nx;
            r_code_q  <= w_code_nx;
            code_n_o  <= w_state_nx == ST_PRESENT ? ~w_code_nx : CODE_IDLE_N;
            gs_n_o    <= w_state_nx != ST_PRESENT;
            valid_o   <= w_state_nx == ST_PRESENT;
            eo_n_o    <= ei_n_i | (|(w_pend_nx & ~mask_i));
        end
    end

    assign pending_o = r_pending;
endmodule
